// File: rtl/pentary_pkg.sv
// ---------------------------------------------------------------------------
// pentary_pkg
// Shared definitions for the pentary memory arbiter slice.
//   PENT_WORD_W  : external memory word width (16 pentary digits x 3 bits)
//   PENT_DIGIT_W : bits per pentary digit
//   arb_state_t  : arbiter FSM state encoding
//   clog2w()     : $clog2 that never returns less than 1, for index widths
// ---------------------------------------------------------------------------
package pentary_pkg;

  localparam int PENT_WORD_W  = 48;
  localparam int PENT_DIGIT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Index width helper: a single-entry selector still needs a 1-bit index.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pentary_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pentary_rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// searching upward from the pointer, wrapping past NUM_REQ-1.
//   i_req : request vector
//   i_ptr : search start channel (held by the parent)
//   o_gnt : one-hot grant (all zero when nothing requests)
//   o_idx : binary index of the granted channel
//   o_any : at least one request present
// ---------------------------------------------------------------------------
module pentary_rr_arbiter
  import pentary_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = clog2w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_chan;
  logic               w_found;
  int                 w_sum;

  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_chan  = '0;
    w_found = 1'b0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Modular add done in int so non-power-of-two channel counts wrap.
      w_sum = int'(i_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_chan = IW'(w_sum);
      if (!w_found && i_req[w_chan]) begin
        w_found       = 1'b1;
        w_gnt[w_chan] = 1'b1;
        w_idx         = w_chan;
      end
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_any = w_found;

endmodule

// File: rtl/pentary_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pentary_mem_arbiter
// N-channel round-robin arbiter in front of the single external memory port.
// Supports single reads, aligned BURST_LEN-word burst reads, acknowledged
// single-word writes and a per-beat mem_ready timeout with error response.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/ready     : per-channel request handshake (ready is one-hot)
//   req_write/burst     : per-channel transaction kind
//   req_addr/wdata      : packed per-channel address / write data
//   rsp_valid           : one-hot response strobe, qualifies rsp_data/last/err
//   rsp_data/last/err   : shared response data, final-beat flag, timeout flag
//   mem_*               : external memory port (level requests, mem_ready ack)
//   busy, grant_id      : transaction in flight, owner of that transaction
// ---------------------------------------------------------------------------
module pentary_mem_arbiter
  import pentary_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int ADDR_W    = PENT_WORD_W,
  parameter  int DATA_W    = PENT_WORD_W,
  parameter  int BURST_LEN = 4,
  parameter  int TIMEOUT   = 64,
  localparam int IW        = clog2w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_burst,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [IW-1:0]             grant_id
);

  localparam int                BEAT_W     = clog2w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BURST_LEN - 1);
  localparam int                TCW        = clog2w(TIMEOUT + 1);
  localparam logic [TCW-1:0]    TO_LIM     = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0]     LAST_ID    = IW'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_gid;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_write;
  logic               r_burst;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [BEAT_W-1:0]  r_beat;
  logic [TCW-1:0]     r_tcnt;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_last;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_addr_sel;
  logic [DATA_W-1:0]  w_wdata_sel;
  logic               w_write_sel;
  logic               w_burst_sel;
  logic               w_last_beat;

  pentary_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // One-hot mux of the winning channel's request fields.
  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        w_wdata_sel = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_write_sel = |(req_write & w_gnt);
  // Writes are always single-word regardless of req_burst.
  assign w_burst_sel = |(req_burst & w_gnt) & ~w_write_sel;
  assign w_last_beat = ~r_burst | (r_beat == BEAT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_gnt       <= '0;
      r_write     <= 1'b0;
      r_burst     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_beat      <= '0;
      r_tcnt      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ACCESS;
            r_gid       <= w_idx;
            r_gnt       <= w_gnt;
            r_write     <= w_write_sel;
            r_burst     <= w_burst_sel;
            r_addr      <= w_burst_sel ? (w_addr_sel & ~ALIGN_MASK) : w_addr_sel;
            r_wdata     <= w_wdata_sel;
            r_beat      <= '0;
            r_tcnt      <= '0;
            r_mem_read  <= ~w_write_sel;
            r_mem_write <= w_write_sel;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            r_state     <= RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rsp_valid <= r_gnt;
            r_rsp_data  <= r_write ? '0 : mem_read_data;
            r_rsp_last  <= w_last_beat;
            r_rsp_err   <= 1'b0;
          end else if ((TIMEOUT != 0) && (r_tcnt == TO_LIM)) begin
            // Abort: error beat is marked last so RESP returns to IDLE and
            // any remaining burst beats are skipped.
            r_state     <= RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rsp_valid <= r_gnt;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_tcnt <= r_tcnt + TCW'(1);
          end
        end

        RESP: begin
          r_rsp_valid <= '0;
          r_rsp_last  <= 1'b0;
          r_rsp_err   <= 1'b0;
          if (r_rsp_last) begin
            r_state <= IDLE;
            r_ptr   <= (r_gid == LAST_ID) ? '0 : r_gid + IW'(1);
          end else begin
            r_state    <= ACCESS;
            r_beat     <= r_beat + BEAT_W'(1);
            r_addr     <= r_addr + ADDR_W'(1);
            r_tcnt     <= '0;
            r_mem_read <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant is offered combinationally in IDLE; masked while reset is held so
  // every output reads zero during reset.
  assign req_ready      = ((r_state == IDLE) && !reset) ? w_gnt : '0;
  assign busy           = (r_state != IDLE);
  assign grant_id       = r_gid;
  assign mem_addr       = r_addr;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_write_data = r_wdata;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_last       = r_rsp_last;
  assign rsp_err        = r_rsp_err;

endmodule

// File: tb/tb_pentary_mem_arbiter.sv
module tb_pentary_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 48;
  localparam int DATA_W  = 48;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_burst;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_last;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_W-1:0]         mem_write_data;
  logic [DATA_W-1:0]         mem_read_data;
  logic                      mem_ready;
  logic                      busy;
  logic [0:0]                grant_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pentary_mem_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (4),
    .TIMEOUT   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_burst      (req_burst),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_last       (rsp_last),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, ".rsp_data"},  64'(rsp_data),  64'd0);
    check({tag, ".rsp_last"},  64'(rsp_last),  64'd0);
    check({tag, ".rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, ".mem_read"},  64'(mem_read),  64'd0);
    check({tag, ".mem_write"}, 64'(mem_write), 64'd0);
    check({tag, ".mem_wdata"}, 64'(mem_write_data), 64'd0);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".grant_id"},  64'(grant_id),  64'd0);
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = '0;
    req_write     = '0;
    req_burst     = '0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_read_data = '0;
    mem_ready     = 1'b0;

    // ---------------- reset state
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // ---------------- single read, ch0, two wait cycles
    req_valid = 2'b01;
    req_addr[0 +: ADDR_W] = 48'h100;
    #1;
    check("rd.req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    check("rd.req_ready_off", 64'(req_ready), 64'h0);
    check("rd.mem_read", 64'(mem_read), 64'h1);
    check("rd.mem_write", 64'(mem_write), 64'h0);
    check("rd.mem_addr", 64'(mem_addr), 64'h100);
    check("rd.busy", 64'(busy), 64'h1);
    check("rd.grant_id", 64'(grant_id), 64'h0);
    tick();
    check("rd.wait1", 64'(mem_read), 64'h1);
    tick();
    check("rd.wait2", 64'(mem_read), 64'h1);
    check("rd.no_rsp", 64'(rsp_valid), 64'h0);
    mem_ready = 1'b1;
    mem_read_data = 48'h123456789ABC;
    tick();
    mem_ready = 1'b0;
    check("rd.rsp_valid", 64'(rsp_valid), 64'h1);
    check("rd.rsp_data", 64'(rsp_data), 64'h123456789ABC);
    check("rd.rsp_last", 64'(rsp_last), 64'h1);
    check("rd.rsp_err", 64'(rsp_err), 64'h0);
    check("rd.mem_read_off", 64'(mem_read), 64'h0);
    tick();
    check("rd.rsp_pulse", 64'(rsp_valid), 64'h0);
    check("rd.idle", 64'(busy), 64'h0);
    check("rd.data_hold", 64'(rsp_data), 64'h123456789ABC);

    // ---------------- burst read, ch1, addr 0x107 -> base 0x104
    req_valid = 2'b10;
    req_burst = 2'b10;
    req_addr[ADDR_W +: ADDR_W] = 48'h107;
    #1;
    check("bu.req_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    req_burst = 2'b00;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bu.addr%0d", k), 64'(mem_addr), 64'h104 + 64'(k));
      check($sformatf("bu.read%0d", k), 64'(mem_read), 64'h1);
      mem_read_data = 48'hA000 + 48'(k);
      tick();
      check($sformatf("bu.valid%0d", k), 64'(rsp_valid), 64'h2);
      check($sformatf("bu.data%0d", k), 64'(rsp_data), 64'hA000 + 64'(k));
      check($sformatf("bu.last%0d", k), 64'(rsp_last), (k == 3) ? 64'h1 : 64'h0);
      tick();
    end
    mem_ready = 1'b0;
    check("bu.idle", 64'(busy), 64'h0);
    check("bu.rsp_off", 64'(rsp_valid), 64'h0);

    // ---------------- fairness from reset, both channels requesting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 2'b11;
    req_addr[0 +: ADDR_W] = 48'h10;
    req_addr[ADDR_W +: ADDR_W] = 48'h20;
    mem_ready = 1'b1;
    mem_read_data = 48'h55;
    #1;
    for (int t = 0; t < 4; t++) begin
      check($sformatf("fa.ready%0d", t), 64'(req_ready), (t % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check($sformatf("fa.gid%0d", t), 64'(grant_id), 64'(t % 2));
      check($sformatf("fa.hold%0d", t), 64'(req_ready), 64'h0);
      tick();
      check($sformatf("fa.rsp%0d", t), 64'(rsp_valid), (t % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    req_valid = 2'b00;
    mem_ready = 1'b0;

    // ---------------- write ack, ch1
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr[ADDR_W +: ADDR_W] = 48'h20;
    req_wdata[DATA_W +: DATA_W] = 48'hABC;
    #1;
    check("wr.req_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    req_write = 2'b00;
    req_wdata[DATA_W +: DATA_W] = 48'hFFFF;
    check("wr.mem_write", 64'(mem_write), 64'h1);
    check("wr.mem_read", 64'(mem_read), 64'h0);
    check("wr.addr", 64'(mem_addr), 64'h20);
    check("wr.wdata", 64'(mem_write_data), 64'hABC);
    tick();
    check("wr.hold_write", 64'(mem_write), 64'h1);
    check("wr.hold_wdata", 64'(mem_write_data), 64'hABC);
    mem_ready = 1'b1;
    mem_read_data = 48'h777;
    tick();
    mem_ready = 1'b0;
    check("wr.rsp_valid", 64'(rsp_valid), 64'h2);
    check("wr.rsp_last", 64'(rsp_last), 64'h1);
    check("wr.rsp_data", 64'(rsp_data), 64'h0);
    check("wr.write_off", 64'(mem_write), 64'h0);
    check("wr.no_read", 64'(mem_read), 64'h0);
    tick();

    // ---------------- timeout, ch0 burst with ch1 waiting
    req_valid = 2'b11;
    req_burst = 2'b01;
    req_addr[0 +: ADDR_W] = 48'h203;
    req_addr[ADDR_W +: ADDR_W] = 48'h300;
    #1;
    check("to.req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    req_burst = 2'b00;
    check("to.base", 64'(mem_addr), 64'h200);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to.read%0d", i), 64'(mem_read), 64'h1);
      check($sformatf("to.norsp%0d", i), 64'(rsp_valid), 64'h0);
      tick();
    end
    check("to.read_off", 64'(mem_read), 64'h0);
    check("to.rsp_valid", 64'(rsp_valid), 64'h1);
    check("to.rsp_err", 64'(rsp_err), 64'h1);
    check("to.rsp_last", 64'(rsp_last), 64'h1);
    check("to.rsp_data", 64'(rsp_data), 64'h0);
    tick();
    check("to.idle", 64'(busy), 64'h0);
    check("to.next_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    check("to.gid1", 64'(grant_id), 64'h1);
    check("to.addr1", 64'(mem_addr), 64'h300);
    mem_ready = 1'b1;
    mem_read_data = 48'h31;
    tick();
    mem_ready = 1'b0;
    check("to.rsp1", 64'(rsp_valid), 64'h2);
    check("to.err_clear", 64'(rsp_err), 64'h0);
    tick();

    // ---------------- reset mid-burst, ch0
    req_valid = 2'b01;
    req_burst = 2'b01;
    req_addr[0 +: ADDR_W] = 48'h40;
    #1;
    check("rm.req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    req_burst = 2'b00;
    mem_ready = 1'b1;
    tick();
    check("rm.beat0", 64'(rsp_valid), 64'h1);
    tick();
    tick();
    check("rm.beat1", 64'(rsp_valid), 64'h1);
    tick();
    check("rm.beat2_access", 64'(mem_addr), 64'h42);
    reset = 1'b1;
    req_valid = 2'b11;
    req_addr[0 +: ADDR_W] = 48'h50;
    req_addr[ADDR_W +: ADDR_W] = 48'h60;
    #1;
    check_all_zero("rm.async");
    tick();
    check("rm.no_rsp_a", 64'(rsp_valid), 64'h0);
    tick();
    check("rm.no_rsp_b", 64'(rsp_valid), 64'h0);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rm.ptr0_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    check("rm.gid", 64'(grant_id), 64'h0);
    check("rm.addr", 64'(mem_addr), 64'h50);
    mem_ready = 1'b1;
    mem_read_data = 48'h99;
    tick();
    mem_ready = 1'b0;
    req_valid = 2'b00;
    check("rm.rsp", 64'(rsp_valid), 64'h1);
    check("rm.rsp_data", 64'(rsp_data), 64'h99);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so a stuck run still terminates with a report.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
